id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage of the 5-stage LoongArch pipeline, directly downstream of fetch. Accepts
//  {pc, inst} from IF under valid/allowin handshake, reads the regfile, forwards from
//  EXE/MEM/WB, stalls on load-use, resolves b/bl/jirl/beq..bgeu and drives br_taken/
//  br_target back to IF. Passes pc, inst and resolved operands to EXE (decode lives there).
// PARAMETERS
//  RESET_PC   32'h1bfffffc  value of ds_pc after reset (matches IF reset pc)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  fs_to_ds_valid in   1   IF holds a valid instruction
//  fs_pc          in   32  pc of IF instruction
//  fs_inst        in   32  instruction word from IF
//  ds_allowin     out  1   ID can accept this cycle
//  br_taken       out  1   taken branch resolved in ID (to IF)
//  br_target      out  32  branch target (to IF)
//  rf_raddr1/2    out  5   regfile read addresses (combinational read)
//  rf_rdata1/2    in   32  regfile read data
//  es_fwd_valid, es_fwd_dest[4:0], es_fwd_data[31:0], es_is_load   EXE producer
//  ms_fwd_valid, ms_fwd_dest[4:0], ms_fwd_data[31:0]               MEM producer
//  ws_fwd_valid, ws_fwd_dest[4:0], ws_fwd_data[31:0]               WB producer
//  es_flush       in   1   EXE-resolved redirect: kill ID contents
//  es_allowin     in   1   EXE can accept
//  ds_to_es_valid out  1   valid handoff to EXE
//  ds_pc, ds_inst out  32  registered pc/inst of ID instruction
//  ds_rj_value    out  32  forwarded rj operand
//  ds_src2_value  out  32  forwarded rk or rd operand (see src2 select)
// BEHAVIOUR
//  Reset: ds_valid=0, ds_pc=RESET_PC, ds_inst=0; so ds_to_es_valid=0, br_taken=0.
//  ds_allowin = ~ds_valid | (ds_ready_go & es_allowin); ds_to_es_valid = ds_valid & ds_ready_go.
//  Edge: es_flush -> ds_valid<=0 (highest prio after reset);
//   else if ds_allowin: ds_valid<=fs_to_ds_valid & ~(br_taken & es_allowin);
//   {ds_pc,ds_inst} load fs_* when ds_allowin & fs_to_ds_valid.
//  Fields: rj=inst[9:5], rk=inst[14:10], rd=inst[4:0].
//  src2 = rd for branch-compare (inst[31:26]=010110..011011) or st.b/h/w
//   (inst[31:22]=0x0A4/0x0A5/0x0A6); src2 = rk when inst[31:22]==0; else unused.
//  rj used unless b (010100), bl (010101), lu12i.w (inst[31:25]=0001010),
//   pcaddu12i (0001110). rf_raddr1=rj, rf_raddr2=src2 field always.
//  Forward per used source, reg 0 never matched: EXE > MEM > WB > rf_rdata.
//  Load-use stall: ds_ready_go=0 iff es_fwd_valid & es_is_load & dest!=0 & dest matches a
//   used source; else ds_ready_go=1.
//  Branch: offs16=sext({inst[25:10],2'b0}); offs26=sext({inst[9:0],inst[25:10],2'b0}).
//   b/bl: pc+offs26; beq/bne/blt/bge/bltu/bgeu: pc+offs16 on cond(rj,rd),
//   blt/bge signed, bltu/bgeu unsigned; jirl (010011): rj+offs16. 32-bit wrap, no trap.
//  br_taken = ds_valid & ds_ready_go & ~es_flush & cond; combinational, held while
//   es_allowin=0. IF instruction accepted on the edge the taken branch leaves is dropped.
//  Stall/flush simultaneous: es_flush wins; br_taken forced 0.
// TESTING
//  1 reset high 2 cycles -> ds_valid=0, ds_allowin=1, br_taken=0, ds_pc=1bfffffc.
//  2 add.w r3 in EXE (data 5), beq r3,r4 (r4 rf=5, offs16=4) at pc 1c000010 -> br_taken=1,
//    br_target=1c000020; next-cycle ID contents (pc 1c000014) discarded, ds_valid=0.
//  3 ld.w r5 in EXE, ID add.w r6,r5,r7 -> ds_ready_go=0 one cycle, ds_allowin=0; next cycle
//    (r5 in MEM, data 0xAA) -> ds_rj_value=0xAA, ds_to_es_valid=1.
//  4 r2 dest in EXE(1), MEM(2), WB(3) simultaneously -> ds_rj_value=1; dest=r0 -> rf value.
//  5 jirl r1,r8,8 with r8=0x1c001000 and es_allowin=0 for 3 cycles -> br_taken held 3 cycles,
//    target 1c001008, ds_allowin=0; es_flush during stall -> ds_valid=0, br_taken=0.
//  6 bltu r1=0xFFFFFFFF vs r2=1 -> not taken; blt same -> taken.

Source files
------------

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : LoongArch decode stage: operand read/forward, load-use stall,
//               branch resolution with redirect back to fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_to_ds_valid,
    input  logic [31:0] fs_pc,
    input  logic [31:0] fs_inst,
    output logic        ds_allowin,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        es_fwd_valid,
    input  logic [4:0]  es_fwd_dest,
    input  logic [31:0] es_fwd_data,
    input  logic        es_is_load,
    input  logic        ms_fwd_valid,
    input  logic [4:0]  ms_fwd_dest,
    input  logic [31:0] ms_fwd_data,
    input  logic        ws_fwd_valid,
    input  logic [4:0]  ws_fwd_dest,
    input  logic [31:0] ws_fwd_data,
    input  logic        es_flush,
    input  logic        es_allowin,
    output logic        ds_to_es_valid,
    output logic [31:0] ds_pc,
    output logic [31:0] ds_inst,
    output logic [31:0] ds_rj_value,
    output logic [31:0] ds_src2_value
);

    localparam logic [5:0] OP_JIRL = 6'b010011;
    localparam logic [5:0] OP_B    = 6'b010100;
    localparam logic [5:0] OP_BL   = 6'b010101;
    localparam logic [5:0] OP_BEQ  = 6'b010110;
    localparam logic [5:0] OP_BNE  = 6'b010111;
    localparam logic [5:0] OP_BLT  = 6'b011000;
    localparam logic [5:0] OP_BGE  = 6'b011001;
    localparam logic [5:0] OP_BLTU = 6'b011010;
    localparam logic [5:0] OP_BGEU = 6'b011011;

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] ds_pc_q, ds_pc_d;
    logic [31:0] ds_inst_q, ds_inst_d;

    logic [5:0]  op6;
    logic [9:0]  op10;
    logic [6:0]  op7;
    logic [4:0]  rj, rk, rd, src2_addr;
    logic        is_brcmp, is_store, is_rrr, rj_used, src2_is_rd, src2_used;
    logic        load_use, ds_ready_go, br_cond;
    logic [31:0] rj_value, src2_value, offs16, offs26;

    assign op6  = ds_inst_q[31:26];
    assign op10 = ds_inst_q[31:22];
    assign op7  = ds_inst_q[31:25];
    assign rj   = ds_inst_q[9:5];
    assign rk   = ds_inst_q[14:10];
    assign rd   = ds_inst_q[4:0];

    assign is_brcmp   = (op6 >= OP_BEQ) && (op6 <= OP_BGEU);
    assign is_store   = (op10 == 10'h0A4) || (op10 == 10'h0A5) || (op10 == 10'h0A6);
    assign is_rrr     = (op10 == 10'h000);
    assign src2_is_rd = is_brcmp | is_store;
    assign src2_used  = src2_is_rd | is_rrr;
    assign rj_used    = ~((op6 == OP_B) || (op6 == OP_BL) ||
                          (op7 == 7'b0001010) || (op7 == 7'b0001110));
    assign src2_addr  = src2_is_rd ? rd : rk;

    assign rf_raddr1 = rj;
    assign rf_raddr2 = src2_addr;

    // Youngest producer wins; r0 is hard-wired zero and never forwarded.
    always_comb begin
        rj_value = rf_rdata1;
        if (rj_used && (rj != 5'd0)) begin
            if (es_fwd_valid && (es_fwd_dest == rj))      rj_value = es_fwd_data;
            else if (ms_fwd_valid && (ms_fwd_dest == rj)) rj_value = ms_fwd_data;
            else if (ws_fwd_valid && (ws_fwd_dest == rj)) rj_value = ws_fwd_data;
        end
    end

    always_comb begin
        src2_value = rf_rdata2;
        if (src2_used && (src2_addr != 5'd0)) begin
            if (es_fwd_valid && (es_fwd_dest == src2_addr))      src2_value = es_fwd_data;
            else if (ms_fwd_valid && (ms_fwd_dest == src2_addr)) src2_value = ms_fwd_data;
            else if (ws_fwd_valid && (ws_fwd_dest == src2_addr)) src2_value = ws_fwd_data;
        end
    end

    assign load_use = es_fwd_valid && es_is_load && (es_fwd_dest != 5'd0) &&
                      ((rj_used && (es_fwd_dest == rj)) ||
                       (src2_used && (es_fwd_dest == src2_addr)));
    assign ds_ready_go = ~load_use;

    assign offs16 = {{14{ds_inst_q[25]}}, ds_inst_q[25:10], 2'b00};
    assign offs26 = {{4{ds_inst_q[9]}}, ds_inst_q[9:0], ds_inst_q[25:10], 2'b00};

    always_comb begin
        br_cond   = 1'b0;
        br_target = ds_pc_q + offs16;
        case (op6)
            OP_B, OP_BL: begin
                br_cond   = 1'b1;
                br_target = ds_pc_q + offs26;
            end
            OP_JIRL: begin
                br_cond   = 1'b1;
                br_target = rj_value + offs16;
            end
            OP_BEQ:  br_cond = (rj_value == src2_value);
            OP_BNE:  br_cond = (rj_value != src2_value);
            OP_BLT:  br_cond = ($signed(rj_value) <  $signed(src2_value));
            OP_BGE:  br_cond = ($signed(rj_value) >= $signed(src2_value));
            OP_BLTU: br_cond = (rj_value <  src2_value);
            OP_BGEU: br_cond = (rj_value >= src2_value);
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken       = ds_valid_q & ds_ready_go & ~es_flush & br_cond;
    assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid_q & ds_ready_go;

    // The fetch-side instruction arriving alongside a departing taken branch is wrong-path.
    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_pc_d    = ds_pc_q;
        ds_inst_d  = ds_inst_q;
        if (es_flush) begin
            ds_valid_d = 1'b0;
        end else if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid & ~(br_taken & es_allowin);
        end
        if (ds_allowin && fs_to_ds_valid) begin
            ds_pc_d   = fs_pc;
            ds_inst_d = fs_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q <= 1'b0;
            ds_pc_q    <= RESET_PC;
            ds_inst_q  <= 32'h0;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_pc_q    <= ds_pc_d;
            ds_inst_q  <= ds_inst_d;
        end
    end

    assign ds_pc         = ds_pc_q;
    assign ds_inst       = ds_inst_q;
    assign ds_rj_value   = rj_value;
    assign ds_src2_value = src2_value;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Self-checking bench for id_stage: directed scenarios plus
//               randomized traffic against a behavioural decode-stage model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc, fs_inst;
    logic        ds_allowin, br_taken;
    logic [31:0] br_target;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        es_fwd_valid, es_is_load, ms_fwd_valid, ws_fwd_valid;
    logic [4:0]  es_fwd_dest, ms_fwd_dest, ws_fwd_dest;
    logic [31:0] es_fwd_data, ms_fwd_data, ws_fwd_data;
    logic        es_flush, es_allowin, ds_to_es_valid;
    logic [31:0] ds_pc, ds_inst, ds_rj_value, ds_src2_value;

    logic [31:0] tb_rf [32];

    always #5 clk = ~clk;

    assign rf_rdata1 = tb_rf[rf_raddr1];
    assign rf_rdata2 = tb_rf[rf_raddr2];

    id_stage #(.RESET_PC(32'h1bfffffc)) dut (
        .clk(clk), .reset(reset),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
        .ds_allowin(ds_allowin), .br_taken(br_taken), .br_target(br_target),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest),
        .es_fwd_data(es_fwd_data), .es_is_load(es_is_load),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data),
        .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
        .es_flush(es_flush), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc), .ds_inst(ds_inst),
        .ds_rj_value(ds_rj_value), .ds_src2_value(ds_src2_value)
    );

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // Architectural view of the ID latch
    logic        m_valid;
    logic [31:0] m_pc, m_inst;

    typedef struct packed {
        logic        allowin;
        logic        to_es;
        logic        taken;
        logic        use_rj;
        logic        use_s2;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] target;
        logic [31:0] rjv;
        logic [31:0] s2v;
    } exp_t;

    exp_t ce;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r);
        if (r != 5'd0) begin
            if (es_fwd_valid && es_fwd_dest == r) return es_fwd_data;
            if (ms_fwd_valid && ms_fwd_dest == r) return ms_fwd_data;
            if (ws_fwd_valid && ws_fwd_dest == r) return ws_fwd_data;
        end
        return tb_rf[r];
    endfunction

    function automatic exp_t model();
        exp_t        e;
        logic [5:0]  op6;
        logic        is_cmp, is_st, is_r3, stall, cond;
        logic [31:0] a, b, o16, o26;
        op6    = m_inst[31:26];
        is_cmp = (op6 >= 6'd22) && (op6 <= 6'd27);
        is_st  = (m_inst[31:22] >= 10'h0A4) && (m_inst[31:22] <= 10'h0A6);
        is_r3  = (m_inst[31:22] == 10'h000);
        e.use_rj = !(op6 == 6'd20 || op6 == 6'd21 ||
                     m_inst[31:25] == 7'b0001010 || m_inst[31:25] == 7'b0001110);
        e.use_s2 = is_cmp || is_st || is_r3;
        e.ra1 = m_inst[9:5];
        e.ra2 = (is_cmp || is_st) ? m_inst[4:0] : m_inst[14:10];
        a = fwd(e.ra1);
        b = fwd(e.ra2);
        e.rjv = a;
        e.s2v = b;
        stall = es_fwd_valid && es_is_load && (es_fwd_dest != 5'd0) &&
                ((e.use_rj && es_fwd_dest == e.ra1) || (e.use_s2 && es_fwd_dest == e.ra2));
        // immediate * 4 as two's complement
        o16 = {16'h0, m_inst[25:10]} << 2;
        if (m_inst[25]) o16 = o16 - 32'h0004_0000;
        o26 = {6'h0, m_inst[9:0], m_inst[25:10]} << 2;
        if (m_inst[9]) o26 = o26 - 32'h1000_0000;
        e.target = m_pc + o16;
        case (op6)
            6'd20, 6'd21: begin cond = 1'b1; e.target = m_pc + o26; end
            6'd19:        begin cond = 1'b1; e.target = a + o16; end
            6'd22:        cond = (a == b);
            6'd23:        cond = (a != b);
            6'd24:        cond = ($signed(a) <  $signed(b));
            6'd25:        cond = ($signed(a) >= $signed(b));
            6'd26:        cond = (a <  b);
            6'd27:        cond = (a >= b);
            default:      cond = 1'b0;
        endcase
        e.taken   = m_valid && !stall && !es_flush && cond;
        e.allowin = !m_valid || (!stall && es_allowin);
        e.to_es   = m_valid && !stall;
        return e;
    endfunction

    // Compare process: every cycle, away from the active edge
    initial forever begin
        @(negedge clk);
        ce = model();
        if (chk_en) begin
            check("allowin",  {31'b0, ds_allowin},     {31'b0, ce.allowin});
            check("to_es",    {31'b0, ds_to_es_valid}, {31'b0, ce.to_es});
            check("br_taken", {31'b0, br_taken},       {31'b0, ce.taken});
            check("ds_pc",    ds_pc,   m_pc);
            check("ds_inst",  ds_inst, m_inst);
            check("raddr1",   {27'b0, rf_raddr1}, {27'b0, ce.ra1});
            check("raddr2",   {27'b0, rf_raddr2}, {27'b0, ce.ra2});
            if (ce.taken) check("br_target", br_target, ce.target);
            if (ce.to_es && ce.use_rj) check("rj_value", ds_rj_value, ce.rjv);
            if (ce.to_es && ce.use_s2) check("src2_value", ds_src2_value, ce.s2v);
        end
    end

    // Model state advance, using the expectation computed for this cycle
    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_pc    = 32'h1bfffffc;
            m_inst  = 32'h0;
        end else begin
            if (es_flush) m_valid = 1'b0;
            else if (ce.allowin) m_valid = fs_to_ds_valid && !(ce.taken && es_allowin);
            if (ce.allowin && fs_to_ds_valid) begin
                m_pc   = fs_pc;
                m_inst = fs_inst;
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic fwd_off();
        es_fwd_valid = 1'b0; es_fwd_dest = 5'd0; es_fwd_data = 32'h0; es_is_load = 1'b0;
        ms_fwd_valid = 1'b0; ms_fwd_dest = 5'd0; ms_fwd_data = 32'h0;
        ws_fwd_valid = 1'b0; ws_fwd_dest = 5'd0; ws_fwd_data = 32'h0;
    endtask

    // Flush ID empty, then hand it one instruction
    task automatic load_id(input logic [31:0] pc, input logic [31:0] inst);
        es_flush = 1'b1; fs_to_ds_valid = 1'b0; es_allowin = 1'b1;
        go();
        es_flush = 1'b0; fs_to_ds_valid = 1'b1; fs_pc = pc; fs_inst = inst;
        go();
        fs_to_ds_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int k;
        w = $urandom;
        w[4:0]   = 5'($urandom_range(0, 7));
        w[9:5]   = 5'($urandom_range(0, 7));
        w[14:10] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 13);
        case (k)
            0:  w[31:26] = 6'b010100;
            1:  w[31:26] = 6'b010101;
            2:  w[31:26] = 6'b010011;
            3, 4, 5, 6, 7, 8: w[31:26] = 6'(22 + k - 3);
            9:  w[31:22] = 10'(10'h0A4 + $urandom_range(0, 2));
            10: w[31:22] = 10'h000;
            11: w[31:25] = 7'b0001010;
            12: w[31:25] = 7'b0001110;
            default: w[31:22] = 10'h0A2;
        endcase
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) tb_rf[i] = (i == 0) ? 32'h0 : rnd_val();
        reset = 1'b1; fs_to_ds_valid = 1'b0; fs_pc = 32'h0; fs_inst = 32'h0;
        es_flush = 1'b0; es_allowin = 1'b1;
        fwd_off();

        // Reset held for two cycles
        go();
        chk_en = 1'b1;
        go();
        look();
        check("lit_rst_allowin", {31'b0, ds_allowin},     32'h1);
        check("lit_rst_taken",   {31'b0, br_taken},       32'h0);
        check("lit_rst_to_es",   {31'b0, ds_to_es_valid}, 32'h0);
        check("lit_rst_pc",      ds_pc, 32'h1bfffffc);
        go();
        reset = 1'b0;

        // beq r3,r4 with r3 forwarded from EXE
        tb_rf[3] = 32'h99; tb_rf[4] = 32'h5;
        load_id(32'h1c000010, {6'b010110, 16'd4, 5'd3, 5'd4});
        es_fwd_valid = 1'b1; es_fwd_dest = 5'd3; es_fwd_data = 32'h5;
        fs_to_ds_valid = 1'b1; fs_pc = 32'h1c000014; fs_inst = 32'h00100C41; es_allowin = 1'b1;
        look();
        check("lit_beq_taken",  {31'b0, br_taken}, 32'h1);
        check("lit_beq_target", br_target, 32'h1c000020);
        go();
        fwd_off(); fs_to_ds_valid = 1'b0;
        look();
        check("lit_beq_drop_valid", {31'b0, ds_to_es_valid}, 32'h0);
        check("lit_beq_drop_pc",    ds_pc, 32'h1c000014);
        go();

        // Load-use on add.w r6,r5,r7
        tb_rf[5] = 32'h55; tb_rf[7] = 32'h77;
        load_id(32'h1c000020, 32'h00101CA6);
        es_fwd_valid = 1'b1; es_fwd_dest = 5'd5; es_is_load = 1'b1; es_fwd_data = 32'h1234;
        fs_to_ds_valid = 1'b1; fs_pc = 32'h1c000024; fs_inst = 32'h03400000;
        look();
        check("lit_lu_to_es",   {31'b0, ds_to_es_valid}, 32'h0);
        check("lit_lu_allowin", {31'b0, ds_allowin},     32'h0);
        go();
        es_fwd_valid = 1'b0; es_is_load = 1'b0;
        ms_fwd_valid = 1'b1; ms_fwd_dest = 5'd5; ms_fwd_data = 32'hAA;
        look();
        check("lit_lu_rj",    ds_rj_value,   32'hAA);
        check("lit_lu_src2",  ds_src2_value, 32'h77);
        check("lit_lu_go",    {31'b0, ds_to_es_valid}, 32'h1);
        check("lit_lu_pc",    ds_pc, 32'h1c000020);
        go();
        fwd_off(); fs_to_ds_valid = 1'b0;

        // Forwarding priority, and r0 never forwarded
        load_id(32'h1c000040, 32'h00100C41);
        es_fwd_valid = 1'b1; es_fwd_dest = 5'd2; es_fwd_data = 32'h1;
        ms_fwd_valid = 1'b1; ms_fwd_dest = 5'd2; ms_fwd_data = 32'h2;
        ws_fwd_valid = 1'b1; ws_fwd_dest = 5'd2; ws_fwd_data = 32'h3;
        es_allowin = 1'b0;
        look();
        check("lit_prio_rj", ds_rj_value, 32'h1);
        go();
        ms_fwd_valid = 1'b0;
        look();
        check("lit_prio_rj_es", ds_rj_value, 32'h1);
        go();
        es_fwd_valid = 1'b0; ms_fwd_valid = 1'b1;
        look();
        check("lit_prio_rj_ms", ds_rj_value, 32'h2);
        go();
        tb_rf[3] = 32'h33;
        es_fwd_valid = 1'b1; es_fwd_dest = 5'd0;
        ms_fwd_valid = 1'b1; ms_fwd_dest = 5'd0;
        ws_fwd_valid = 1'b1; ws_fwd_dest = 5'd0;
        load_id(32'h1c000044, 32'h00100C01);
        look();
        check("lit_r0_rj",   ds_rj_value,   32'h0);
        check("lit_r0_src2", ds_src2_value, 32'h33);
        go();
        fwd_off();

        // jirl held while EXE back-pressures, then flushed
        tb_rf[8] = 32'h1c001000;
        load_id(32'h1c000050, {6'b010011, 16'd2, 5'd8, 5'd1});
        es_allowin = 1'b0; fs_to_ds_valid = 1'b1; fs_pc = 32'h1c000054; fs_inst = 32'h00100C41;
        for (int i = 0; i < 3; i++) begin
            look();
            check("lit_jirl_taken",   {31'b0, br_taken},   32'h1);
            check("lit_jirl_target",  br_target,           32'h1c001008);
            check("lit_jirl_allowin", {31'b0, ds_allowin}, 32'h0);
            go();
        end
        es_flush = 1'b1;
        look();
        check("lit_flush_taken", {31'b0, br_taken}, 32'h0);
        go();
        es_flush = 1'b0; fs_to_ds_valid = 1'b0; es_allowin = 1'b1;
        look();
        check("lit_flush_valid", {31'b0, ds_to_es_valid}, 32'h0);
        go();

        // Unsigned vs signed compare of 0xFFFFFFFF against 1
        tb_rf[1] = 32'hFFFF_FFFF; tb_rf[2] = 32'h1;
        load_id(32'h1c000060, {6'b011010, 16'd4, 5'd1, 5'd2});
        look();
        check("lit_bltu_taken", {31'b0, br_taken}, 32'h0);
        go();
        load_id(32'h1c000070, {6'b011000, 16'd4, 5'd1, 5'd2});
        look();
        check("lit_blt_taken",  {31'b0, br_taken}, 32'h1);
        check("lit_blt_target", br_target, 32'h1c000080);
        go();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 199) == 0);
            fs_to_ds_valid = ($urandom_range(0, 3) != 0);
            fs_pc          = $urandom;
            fs_pc[1:0]     = 2'b00;
            fs_inst        = gen_inst();
            es_allowin     = ($urandom_range(0, 3) != 0);
            es_flush       = ($urandom_range(0, 11) == 0);
            es_fwd_valid   = 1'($urandom_range(0, 1));
            es_fwd_dest    = 5'($urandom_range(0, 7));
            es_fwd_data    = rnd_val();
            es_is_load     = ($urandom_range(0, 2) == 0);
            ms_fwd_valid   = 1'($urandom_range(0, 1));
            ms_fwd_dest    = 5'($urandom_range(0, 7));
            ms_fwd_data    = rnd_val();
            ws_fwd_valid   = 1'($urandom_range(0, 1));
            ws_fwd_dest    = 5'($urandom_range(0, 7));
            ws_fwd_data    = rnd_val();
            if ($urandom_range(0, 3) == 0) tb_rf[$urandom_range(1, 7)] = rnd_val();
            go();
        end

        look();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
